// File: rtl/lfsr_pkg.sv
// lfsr_pkg: maximal-length Galois feedback masks (right-shift form) and the
// arbiter state type shared by the LFSR arbiter block.
package lfsr_pkg;

  // Bit k set means tap x^(k+1). State shifts right and the mask is applied
  // when the bit shifted out is 1.
  localparam logic [3:0]  POLY_MAX_4  = 4'hC;     // x^4+x^3+1
  localparam logic [7:0]  POLY_MAX_8  = 8'hB8;    // x^8+x^6+x^5+x^4+1
  localparam logic [15:0] POLY_MAX_16 = 16'hB400; // x^16+x^14+x^13+x^11+1

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: combinational Galois LFSR step. The caller owns the state
// register; this block only computes the successor state and the output word
// taken from the current state.
module lfsr_galois
  import lfsr_pkg::*;
#(
  parameter int                DEGREE       = 16,
  parameter logic [DEGREE-1:0] POLYNOMIAL   = DEGREE'(POLY_MAX_16),
  parameter int                OUTPUT_WIDTH = 8
) (
  input  logic [DEGREE-1:0]       state,
  output logic [DEGREE-1:0]       next_state,
  output logic [OUTPUT_WIDTH-1:0] data
);

  assign next_state = (state >> 1) ^ (state[0] ? POLYNOMIAL : '0);

  // Output word is the low end of the current state; zero-extended when the
  // requested word is wider than the register.
  generate
    if (OUTPUT_WIDTH <= DEGREE) begin : g_narrow
      assign data = state[OUTPUT_WIDTH-1:0];
    end else begin : g_wide
      assign data = {{(OUTPUT_WIDTH-DEGREE){1'b0}}, state};
    end
  endgenerate

endmodule

// File: rtl/axi4s_lfsr_arb.sv
// axi4s_lfsr_arb: N_SRC AXI4-Stream requesters share one LFSR core with
// packet-granular round-robin arbitration. Each packet restarts the LFSR at
// SEED. One output register stage, one-cycle latency, full throughput inside
// a packet and a one-cycle arbitration bubble between packets.
//
// Build option: define AXI4S_LFSR_ARB_SCRAMBLE_EN to XOR the LFSR word onto the
// source payload (scrambler). Without it the block is a generator and the
// source payload is ignored; handshaking is identical in both builds.
module axi4s_lfsr_arb
  import lfsr_pkg::*;
#(
  parameter int                     N_SRC       = 4,
  parameter int                     TDATA_WIDTH = 8,
  parameter int                     POLY_DEGREE = 16,
  parameter logic [POLY_DEGREE-1:0] POLYNOMIAL  = POLY_DEGREE'(POLY_MAX_16),
  parameter logic [POLY_DEGREE-1:0] SEED        = POLY_DEGREE'(1),
  localparam int                    IDW         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_SRC-1:0]             target_tvalid,
  output logic [N_SRC-1:0]             target_tready,
  input  logic [N_SRC-1:0]             target_tlast,
  input  logic [N_SRC*TDATA_WIDTH-1:0] target_tdata,
  output logic                         initiator_tvalid,
  input  logic                         initiator_tready,
  output logic                         initiator_tlast,
  output logic [TDATA_WIDTH-1:0]       initiator_tdata,
  output logic [IDW-1:0]               initiator_tid
);

  arb_state_t             state_q;
  logic [IDW-1:0]         grant_q;
  logic [IDW-1:0]         last_grant_q;
  logic [POLY_DEGREE-1:0] lfsr_q;
  logic [POLY_DEGREE-1:0] lfsr_next;
  logic [TDATA_WIDTH-1:0] lfsr_data;

  logic                   out_valid_q;
  logic                   out_last_q;
  logic [TDATA_WIDTH-1:0] out_data_q;
  logic [TDATA_WIDTH-1:0] out_data_d;
  logic [IDW-1:0]         out_tid_q;

  logic                   can_accept;
  logic                   accept;
  logic                   src_valid;
  logic                   src_last;
  logic [TDATA_WIDTH-1:0] src_data;
  logic                   rr_found;
  logic [IDW-1:0]         rr_sel;

  lfsr_galois #(
    .DEGREE       (POLY_DEGREE),
    .POLYNOMIAL   (POLYNOMIAL),
    .OUTPUT_WIDTH (TDATA_WIDTH)
  ) u_lfsr (
    .state      (lfsr_q),
    .next_state (lfsr_next),
    .data       (lfsr_data)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign can_accept = !out_valid_q || initiator_tready;
  assign accept     = (state_q == LOCKED) && src_valid && can_accept;

  // Select the granted source's handshake and payload.
  always_comb begin
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_data  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == IDW'(i)) begin
        src_valid = target_tvalid[i];
        src_last  = target_tlast[i];
        src_data  = target_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
      end
    end
  end

  // Round-robin search: first valid source at or after last_grant+1, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = last_grant_q;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!rr_found && target_tvalid[(int'(last_grant_q) + k) % N_SRC]) begin
        rr_found = 1'b1;
        rr_sel   = IDW'((int'(last_grant_q) + k) % N_SRC);
      end
    end
  end

  // Only the locked source ever sees tready; everything is quiet in reset.
  always_comb begin
    target_tready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (aresetn && (state_q == LOCKED) && can_accept && (grant_q == IDW'(i))) begin
        target_tready[i] = 1'b1;
      end
    end
  end

`ifdef AXI4S_LFSR_ARB_SCRAMBLE_EN
  assign out_data_d = src_data ^ lfsr_data;
`else
  logic unused_src_data;
  assign unused_src_data = ^src_data;
  assign out_data_d      = lfsr_data;
`endif

  // Arbitration FSM, LFSR state and output register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(N_SRC - 1);
      lfsr_q       <= SEED;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_tid_q    <= '0;
    end else begin
      if (out_valid_q && initiator_tready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (rr_found) begin
            grant_q <= rr_sel;
            lfsr_q  <= SEED;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_last_q  <= src_last;
            out_tid_q   <= grant_q;
            lfsr_q      <= lfsr_next;
            if (src_last) begin
              state_q      <= IDLE;
              last_grant_q <= grant_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign initiator_tvalid = out_valid_q;
  assign initiator_tlast  = out_last_q;
  assign initiator_tdata  = out_data_q;
  assign initiator_tid    = out_tid_q;

endmodule

// File: tb/tb_axi4s_lfsr_arb.sv
// tb_axi4s_lfsr_arb: randomized and directed packet traffic against a
// transaction-level model of the arbiter (packet round-robin over sources with
// pending packets, LFSR sequence restarted from SEED per packet).
module tb_axi4s_lfsr_arb;

  localparam int          N      = 4;
  localparam int          W      = 8;
  localparam logic [15:0] SEED   = 16'h0001;
  localparam logic [15:0] POLY   = 16'hB400; // x^16+x^14+x^13+x^11+1
  localparam int          BUDGET = 4000;
`ifdef AXI4S_LFSR_ARB_SCRAMBLE_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] id;
  } beat_t;

  logic clk = 1'b0;
  logic aresetn;
  logic [N-1:0]   tvalid, tready, tlast;
  logic [N*W-1:0] tdata;
  logic           o_valid, o_ready, o_last;
  logic [W-1:0]   o_data;
  logic [1:0]     o_tid;
  logic [N-1:0]   t2_valid, t2_ready, t2_last;
  logic [N*W-1:0] t2_data;
  logic           o2_valid, o2_ready, o2_last;
  logic [W-1:0]   o2_data;
  logic [1:0]     o2_tid;

  int checks = 0;
  int errors = 0;

  logic [7:0] sq_data[N][$];
  bit         sq_last[N][$];
  bit         mid[N];
  beat_t      exp_q[$];
  logic [7:0] obs_q[$];
  int         exp_total;

  always #5 clk = ~clk;

  axi4s_lfsr_arb dut (
    .aclk(clk), .aresetn(aresetn),
    .target_tvalid(tvalid), .target_tready(tready), .target_tlast(tlast), .target_tdata(tdata),
    .initiator_tvalid(o_valid), .initiator_tready(o_ready), .initiator_tlast(o_last),
    .initiator_tdata(o_data), .initiator_tid(o_tid)
  );

  // Second instance used as the descrambler for the chained scenario.
  axi4s_lfsr_arb dut2 (
    .aclk(clk), .aresetn(aresetn),
    .target_tvalid(t2_valid), .target_tready(t2_ready), .target_tlast(t2_last), .target_tdata(t2_data),
    .initiator_tvalid(o2_valid), .initiator_tready(o2_ready), .initiator_tlast(o2_last),
    .initiator_tdata(o2_data), .initiator_tid(o2_tid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  task automatic add_beat(input int src, input logic [7:0] d, input bit l);
    sq_data[src].push_back(d);
    sq_last[src].push_back(l);
  endtask

  task automatic add_packet(input int src, input int len);
    for (int k = 0; k < len; k++) add_beat(src, 8'($urandom), (k == len - 1));
  endtask

  // Expected output stream: serve whole packets, pointer starts at N-1 after
  // reset, next served source is the first with a pending packet after it.
  task automatic build_model();
    int pos[N];
    int ptr;
    int sel;
    logic [15:0] st;
    beat_t b;
    exp_q.delete();
    for (int i = 0; i < N; i++) pos[i] = 0;
    ptr = N - 1;
    while (1) begin
      sel = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (ptr + k) % N;
        if (sel < 0 && pos[idx] < sq_data[idx].size()) sel = idx;
      end
      if (sel < 0) break;
      st = SEED;
      while (1) begin
        b.d  = st[7:0] ^ (SCR ? sq_data[sel][pos[sel]] : 8'h00);
        b.l  = sq_last[sel][pos[sel]];
        b.id = 2'(sel);
        exp_q.push_back(b);
        pos[sel]++;
        st = lfsr_step(st);
        if (b.l) break;
      end
      ptr = sel;
    end
    exp_total = exp_q.size();
  endtask

  task automatic drive(input int gap_pct, input int stall_pct, input int hold_at,
                       input int gap_at, input int cyc);
    for (int i = 0; i < N; i++) begin
      if (sq_data[i].size() > 0) begin
        tvalid[i] = 1'b1;
        if (mid[i]) begin
          if ($urandom_range(99) < gap_pct) tvalid[i] = 1'b0;
          if (gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 3) tvalid[i] = 1'b0;
        end
        tdata[i*W +: W] = sq_data[i][0];
        tlast[i]        = sq_last[i][0];
      end else begin
        tvalid[i]       = 1'b0;
        tlast[i]        = 1'b0;
        tdata[i*W +: W] = 8'($urandom);
      end
    end
    o_ready = ($urandom_range(99) >= stall_pct);
    if (hold_at >= 0 && cyc >= hold_at && cyc < hold_at + 5) o_ready = 1'b0;
  endtask

  task automatic run_phase(input int gap_pct, input int stall_pct, input int hold_at,
                           input int gap_at, input int abort_acc);
    int cyc, acc_total, active;
    bit prev_tl, prev_stall, tl_acc, done;
    logic [11:0] prev_bundle;
    logic [N-1:0] acc, others;
    beat_t e;
    build_model();
    obs_q.delete();
    cyc = 0; acc_total = 0; active = -1;
    prev_tl = 0; prev_stall = 0; prev_bundle = '0; done = 0;
    drive(gap_pct, stall_pct, hold_at, gap_at, 0);
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      chk("tready_onehot", 32'($countones(tready) <= 1), 32'd1);
      if (o_valid && !o_ready) chk("tready_stall", tready, 0);
      if (active >= 0) begin
        others = tready;
        others[active] = 1'b0;
        chk("tready_lock", others, 0);
      end
      if (prev_tl) chk("bubble_tready", tready, 0);
      if (prev_stall) chk("hold_stable", {o_valid, o_last, o_tid, o_data}, prev_bundle);
      if (o_valid && o_ready) begin
        obs_q.push_back(o_data);
        if (exp_q.size() == 0) chk("beat_count", obs_q.size(), exp_total);
        else begin
          e = exp_q.pop_front();
          chk("out_tid", o_tid, e.id);
          chk("out_data", o_data, e.d);
          chk("out_last", o_last, e.l);
        end
      end
      prev_stall  = o_valid && !o_ready;
      prev_bundle = {o_valid, o_last, o_tid, o_data};
      acc    = tvalid & tready;
      tl_acc = 0;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          acc_total++;
          if (sq_last[i][0]) begin
            mid[i] = 0; tl_acc = 1; active = -1;
          end else begin
            mid[i] = 1; active = i;
          end
          sq_data[i].delete(0);
          sq_last[i].delete(0);
        end
      end
      prev_tl = tl_acc;
      if (abort_acc > 0 && acc_total >= abort_acc) return;
      if (exp_q.size() == 0) done = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
        drive(gap_pct, stall_pct, hold_at, gap_at, cyc);
      end
    end
    if (!done) chk("timeout_pending_beats", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    aresetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", o_valid, 0);
    chk("rst_tdata", o_data, 0);
    chk("rst_tlast", o_last, 0);
    chk("rst_tid", o_tid, 0);
    chk("rst_tready", tready, 0);
    chk("rst2_tvalid", o2_valid, 0);
    for (int i = 0; i < N; i++) begin
      sq_data[i].delete();
      sq_last[i].delete();
      mid[i] = 0;
    end
    tvalid = '0; tlast = '0; tdata = '0; o_ready = 1'b1;
    @(posedge clk); #1;
    aresetn = 1'b1;
  endtask

  // Feed captured scrambled beats into the second instance as source 0.
  task automatic run_chain(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
    logic [7:0] pay[3];
    logic [15:0] st;
    logic [7:0] expd;
    int sent, got, cyc;
    pay = '{p0, p1, p2};
    chk("chain_src_len", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      st = SEED; sent = 0; got = 0; cyc = 0;
      while (got < 3 && cyc < 200) begin
        if (sent < 3) begin
          t2_valid[0]   = 1'b1;
          t2_data[7:0]  = obs_q[sent];
          t2_last[0]    = (sent == 2);
        end else begin
          t2_valid[0] = 1'b0;
          t2_last[0]  = 1'b0;
        end
        @(negedge clk);
        if (o2_valid && o2_ready) begin
          expd = SCR ? pay[got] : st[7:0];
          chk("chain_data", o2_data, expd);
          chk("chain_last", o2_last, (got == 2));
          st = lfsr_step(st);
          got++;
        end
        if (t2_valid[0] && t2_ready[0]) sent++;
        @(posedge clk); #1;
        cyc++;
      end
      t2_valid = '0;
      t2_last  = '0;
      if (got < 3) chk("chain_timeout", got, 3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    tvalid = '0; tlast = '0; tdata = '0; o_ready = 1'b1;
    t2_valid = '0; t2_last = '0; t2_data = '0; o2_ready = 1'b1;
    for (int i = 0; i < N; i++) mid[i] = 0;

    // Two 3-beat zero-payload packets on sources 0 and 2.
    do_reset();
    for (int k = 0; k < 3; k++) add_beat(0, 8'h00, k == 2);
    for (int k = 0; k < 3; k++) add_beat(2, 8'h00, k == 2);
    run_phase(0, 0, -1, -1, 0);

    // All sources continuously valid with single-beat packets.
    do_reset();
    for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) add_packet(s, 1);
    run_phase(0, 0, -1, -1, 0);

    // Output stalled for 5 cycles mid-packet.
    do_reset();
    add_packet(1, 6);
    run_phase(0, 0, 4, -1, 0);

    // Granted source drops tvalid for 3 cycles while source 1 waits.
    do_reset();
    add_packet(0, 4);
    add_packet(1, 2);
    run_phase(0, 0, -1, 3, 0);

    // Randomized traffic with growing gaps and backpressure.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int p = 0; p < 30; p++) add_packet($urandom_range(N - 1), $urandom_range(1, 5));
      run_phase(r * 20, 10 + r * 25, -1, -1, 0);
    end

    // Reset during beat 2 of a 4-beat packet, then restart from SEED at source 0.
    do_reset();
    add_packet(2, 4);
    run_phase(0, 0, -1, -1, 2);
    do_reset();
    add_packet(2, 2);
    add_packet(0, 3);
    run_phase(0, 0, -1, -1, 0);

    // Scramble then descramble through the second instance.
    do_reset();
    add_beat(0, 8'hA5, 1'b0);
    add_beat(0, 8'h3C, 1'b0);
    add_beat(0, 8'hFF, 1'b1);
    run_phase(0, 0, -1, -1, 0);
    run_chain(8'hA5, 8'h3C, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4s_lfsr_arb.md
AXI4S_LFSR_ARB -- requirements
Module: axi4s_lfsr_arb

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of AXI4-Stream requesters (2..16).
REQ-002 SHALL have parameter TDATA_WIDTH, default 8, data width of all streams.
REQ-003 SHALL have parameter POLY_DEGREE, default 16, LFSR degree.
REQ-004 SHALL have parameter POLYNOMIAL, default POLY_MAX_16 from lfsr_pkg, LFSR feedback taps.
REQ-005 SHALL have parameter SEED, default 1, LFSR state loaded at every packet start.
REQ-006 SHALL have port aclk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port aresetn, input, 1, synchronous active-low reset.
REQ-008 SHALL have port target_tvalid/target_tready/target_tlast, input/output/input, N_SRC each, per-source handshake and end of packet.
REQ-009 SHALL have port target_tdata, input, N_SRC*TDATA_WIDTH, per-source data; source i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH].
REQ-010 SHALL have port initiator_tvalid/tready/tlast, output/input/output, 1 each, merged output handshake.
REQ-011 SHALL have port initiator_tdata, output, TDATA_WIDTH, scrambled or generated data.
REQ-012 SHALL have port initiator_tid, output, $clog2(N_SRC) (min 1), index of the source that produced the beat.

Function
REQ-013 SHALL share one LFSR core between all sources using packet-granular round-robin arbitration.
REQ-014 SHALL implement FSM states IDLE and LOCKED.
REQ-015 In IDLE: grant the first valid source at or after (last_grant+1) mod N_SRC, load LFSR state with SEED, and enter LOCKED in the same cycle; no beat is accepted in that cycle.
REQ-016 In LOCKED: assert target_tready only for the granted source, only when the output register can accept (!initiator_tvalid || initiator_tready).
REQ-017 All non-granted target_tready bits SHALL be 0 at all times.
REQ-018 On an accepted beat: register initiator_tdata, initiator_tlast, and initiator_tid, set initiator_tvalid, and advance LFSR state to next_state.
REQ-019 Latency SHALL be 1 cycle, input accept to output valid; full throughput (1 beat/cycle) within a packet.
REQ-020 An accepted beat with target_tlast=1 SHALL return the FSM to IDLE and record last_grant; the one-cycle arbitration bubble between packets is required.
REQ-021 initiator_tvalid SHALL clear after an output handshake with no new beat accepted in the same cycle; a simultaneous handshake and accept SHALL keep it high with new data.
REQ-022 Output SHALL hold stable while initiator_tvalid=1 and initiator_tready=0.
REQ-023 A granted source that deasserts tvalid mid-packet SHALL keep the grant; no other source is served until its tlast is accepted.
REQ-024 Round-robin pointer SHALL wrap from N_SRC-1 to 0; with a single active source, that source is re-granted every packet.

Reset
REQ-025 While aresetn=0 at a rising edge: FSM=IDLE, last_grant=N_SRC-1 (first grant favours source 0), LFSR state=SEED, initiator_tvalid=0, initiator_tdata=0, initiator_tlast=0, initiator_tid=0, all target_tready=0.
REQ-026 Reset mid-packet SHALL discard the packet in flight and the pending output beat, with no further beats from it.

Configuration
REQ-027 Macro AXI4S_LFSR_ARB_SCRAMBLE_EN, when defined: initiator_tdata = target_tdata XOR lfsr_data.
REQ-028 When the macro is undefined: initiator_tdata = lfsr_data and input data is ignored (generator mode); the handshake is identical in both modes.

Structure
REQ-029 lfsr_pkg SHALL hold the polynomial constants (POLY_MAX_16 etc.) and an arb_state_t enum {IDLE, LOCKED}.
REQ-030 SHALL instantiate one lfsr_galois sub-module (state, next_state, data; OUTPUT_WIDTH=TDATA_WIDTH) as the shared core; arbitration and registers stay in this module.

Verification
REQ-031 Scenario: reset, then sources 0 and 2 each present a 3-beat packet with tdata=0x00, SCRAMBLE_EN defined, tready=1 -> source 0's packet first, then a 1-cycle bubble, then source 2's; tid=0,0,0,2,2,2; both packets carry an identical 3-beat LFSR sequence.
REQ-032 Scenario: all 4 sources continuously valid with 1-beat packets -> grant order 0,1,2,3,0,1 and tid follows it.
REQ-033 Scenario: initiator_tready held 0 for 5 cycles mid-packet -> output holds its value, granted tready=0, LFSR does not advance; stream resumes without beat loss or duplication.
REQ-034 Scenario: scrambled output (SCRAMBLE_EN defined) fed to a second instance with a matching SEED -> original payload 0xA5,0x3C,0xFF recovered.
REQ-035 Scenario: aresetn pulsed low during beat 2 of a 4-beat packet -> all outputs 0; next packet starts from SEED and is granted to source 0.
REQ-036 Scenario: granted source drops tvalid for 3 cycles mid-packet while source 1 is valid -> source 1 receives no tready until the granted tlast is accepted.
